// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges EX and LSU results, buffers EX in a FIFO, tracks pending loads.
// Latency: 1 cycle from grant to reg_wen_o/reg_waddr_o/reg_wdata_o; busy queries are combinational.
// Backpressure: ex_ready_o drops when the FIFO is full; lsu_ready_o drops on the starvation turn. Optional WB_STALL_CNT_EN adds stall_cnt_o.

module wb_arbiter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic              lsu_issue_i,
    input  logic [ADDR_W-1:0] lsu_issue_rd_i,
    input  logic [ADDR_W-1:0] rs1_raddr_i,
    input  logic [ADDR_W-1:0] rs2_raddr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wen_o
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);
    localparam int NREG = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_item_t;

    wb_item_t  fifo_head;
    wb_item_t  ex_live;
    wb_item_t  ex_cand;
    wb_item_t  win;
    logic      fifo_empty;
    logic      fifo_full;
    logic      fifo_push;
    logic      fifo_pop;
    logic      ex_pending;
    logic      starve_hit;
    logic      lsu_grant;
    logic      ex_grant;
    logic [1:0] starve_cnt;
    logic      out_lsu;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    assign ex_live     = '{addr: ex_waddr_i, data: ex_wdata_i};
    assign ex_ready_o  = !fifo_full;
    assign ex_pending  = !fifo_empty || ex_valid_i;
    assign starve_hit  = (starve_cnt == 2'd2);
    assign lsu_grant   = lsu_valid_i && !(ex_pending && starve_hit);
    assign lsu_ready_o = lsu_grant;
    assign ex_grant    = ex_pending && !lsu_grant;
    assign ex_cand     = fifo_empty ? ex_live : fifo_head;
    assign win         = lsu_grant ? '{addr: lsu_waddr_i, data: lsu_wdata_i} : ex_cand;

    // A live EX item granted while the FIFO is empty bypasses storage entirely.
    assign fifo_push = ex_valid_i && ex_ready_o && !(fifo_empty && ex_grant);
    assign fifo_pop  = !fifo_empty && ex_grant;

    wb_arbiter_fifo #(
        .W     ($bits(wb_item_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ex_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (fifo_push),
        .push_dat (ex_live),
        .pop_vld  (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Set after clear so a re-issued load keeps its register pending.
    always_comb begin
        busy_nxt = busy;
        if (lsu_grant)   busy_nxt[lsu_waddr_i]    = 1'b0;
        if (lsu_issue_i) busy_nxt[lsu_issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt  <= 2'd0;
            busy        <= '0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            out_lsu     <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (!ex_pending || ex_grant)
                starve_cnt <= 2'd0;
            else if (lsu_grant && !starve_hit)
                starve_cnt <= starve_cnt + 2'd1;

            if ((lsu_grant || ex_grant) && win.addr != '0) begin
                reg_wen_o   <= 1'b1;
                reg_waddr_o <= win.addr;
                reg_wdata_o <= win.data;
                out_lsu     <= lsu_grant;
            end else begin
                reg_wen_o   <= 1'b0;
            end
        end
    end

    // The write-back cycle still reports busy so ID cannot read the stale register-file value.
    assign rs1_busy_o = (rs1_raddr_i != '0) &&
                        (busy[rs1_raddr_i] || (reg_wen_o && out_lsu && reg_waddr_o == rs1_raddr_i));
    assign rs2_busy_o = (rs2_raddr_i != '0) &&
                        (busy[rs2_raddr_i] || (reg_wen_o && out_lsu && reg_waddr_o == rs2_raddr_i));

`ifdef WB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_o <= '0;
        else if (ex_valid_i && !ex_ready_o)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif
endmodule
